load_use_stall_ctrl: RTL and testbench

- Parametrised load-use hazard detection and stall sequencer for the pipelined MIPS core, sitting between the ID/EX pipeline register and the PC / IF-ID write controls.
- Detects a consumer in ID of a register being loaded by the instruction in EX, then freezes PC and IF/ID while injecting bubbles for a configurable number of cycles to cover multi-cycle data memory.
- Supersedes the fixed single-cycle stall: adds variable load latency, explicit source-use qualifiers, $zero exclusion, flush abort and a stall statistics counter.

---
 rtl/load_use_stall_ctrl.sv | 108 ++++++++++
 tb/tb_load_use_stall_ctrl.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/load_use_stall_ctrl.sv
// Load-use hazard detector and stall sequencer: freezes PC and IF/ID and injects
// ID/EX bubbles for LOAD_LATENCY cycles per hazard, with flush abort and statistics.
module load_use_stall_ctrl #(
  parameter int unsigned REG_ADDR_W   = 5,
  parameter int unsigned LOAD_LATENCY = 1,
  parameter int unsigned CNT_W        = 16
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  EX_MemoryRead,
  input  logic [REG_ADDR_W-1:0] EX_rt,
  input  logic [REG_ADDR_W-1:0] ID_rs,
  input  logic [REG_ADDR_W-1:0] ID_rt,
  input  logic                  ID_UsesRs,
  input  logic                  ID_UsesRt,
  input  logic                  Flush,
  output logic                  PC_WriteEnable,
  output logic                  IFID_WriteEnable,
  output logic                  StallFlush,
  output logic                  Stalling,
  output logic [CNT_W-1:0]      StallCount,
  input  logic                  ClearCount
);

  localparam int unsigned RW = (LOAD_LATENCY > 1) ? $clog2(LOAD_LATENCY) : 1;

  typedef enum logic {
    IDLE  = 1'b0,
    STALL = 1'b1
  } state_t;

  state_t        state, state_next;
  logic [RW-1:0] remain, remain_next;
  logic          rs_match, rt_match, ex_rt_nz;
  logic          hazard;
  logic          stall;

  // Compare first, then qualify with the use bit, so an X use flag on a
  // mismatching operand resolves to 0 instead of propagating.
  assign rs_match = (EX_rt == ID_rs);
  assign rt_match = (EX_rt == ID_rt);
  assign ex_rt_nz = (EX_rt != '0);
  assign hazard   = EX_MemoryRead & ex_rt_nz &
                    ((rs_match & ID_UsesRs) | (rt_match & ID_UsesRt));

  always_comb begin
    state_next  = state;
    remain_next = remain;
    stall       = 1'b0;
    unique case (state)
      IDLE: begin
        stall = hazard & ~Flush;
        if (stall && (LOAD_LATENCY > 1)) begin
          remain_next = RW'(LOAD_LATENCY - 1);
          state_next  = STALL;
        end
      end
      STALL: begin
        if (Flush) begin
          stall       = 1'b0;
          remain_next = '0;
          state_next  = IDLE;
        end else begin
          stall       = 1'b1;
          remain_next = remain - RW'(1);
          if (remain == RW'(1)) begin
            state_next = IDLE;
          end
        end
      end
      default: begin
        state_next  = IDLE;
        remain_next = '0;
      end
    endcase
    // Reset overrides the sequencer combinationally so the pipeline is released
    // the instant reset_n falls, without waiting for a clock edge.
    if (!reset_n) begin
      stall = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state  <= IDLE;
      remain <= '0;
    end else begin
      state  <= state_next;
      remain <= remain_next;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      StallCount <= '0;
    end else if (ClearCount) begin
      StallCount <= '0;
    end else if (stall && (StallCount != '1)) begin
      StallCount <= StallCount + CNT_W'(1);
    end
  end

  assign PC_WriteEnable   = ~stall;
  assign IFID_WriteEnable = ~stall;
  assign StallFlush       = stall;
  assign Stalling         = (state == STALL);

endmodule

// File: tb/tb_load_use_stall_ctrl.sv
// Directed bench for load_use_stall_ctrl: four instances with different latency /
// counter widths share one stimulus bus; each scenario checks the relevant instance.
module tb_load_use_stall_ctrl;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       mem_read;
  logic [4:0] ex_rt, id_rs, id_rt;
  logic       uses_rs, uses_rt;
  logic       flush;
  logic       clear_count;

  logic pc1, ifid1, sf1, st1;  logic [15:0] cnt1;
  logic pc3, ifid3, sf3, st3;  logic [15:0] cnt3;
  logic pc4, ifid4, sf4, st4;  logic [15:0] cnt4;
  logic pcs, ifids, sfs, sts;  logic [1:0]  cnts;

  int nvec = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  load_use_stall_ctrl #(.REG_ADDR_W(5), .LOAD_LATENCY(1), .CNT_W(16)) u1 (
    .clk(clk), .reset_n(reset_n), .EX_MemoryRead(mem_read), .EX_rt(ex_rt),
    .ID_rs(id_rs), .ID_rt(id_rt), .ID_UsesRs(uses_rs), .ID_UsesRt(uses_rt),
    .Flush(flush), .PC_WriteEnable(pc1), .IFID_WriteEnable(ifid1),
    .StallFlush(sf1), .Stalling(st1), .StallCount(cnt1), .ClearCount(clear_count));

  load_use_stall_ctrl #(.REG_ADDR_W(5), .LOAD_LATENCY(3), .CNT_W(16)) u3 (
    .clk(clk), .reset_n(reset_n), .EX_MemoryRead(mem_read), .EX_rt(ex_rt),
    .ID_rs(id_rs), .ID_rt(id_rt), .ID_UsesRs(uses_rs), .ID_UsesRt(uses_rt),
    .Flush(flush), .PC_WriteEnable(pc3), .IFID_WriteEnable(ifid3),
    .StallFlush(sf3), .Stalling(st3), .StallCount(cnt3), .ClearCount(clear_count));

  load_use_stall_ctrl #(.REG_ADDR_W(5), .LOAD_LATENCY(4), .CNT_W(16)) u4 (
    .clk(clk), .reset_n(reset_n), .EX_MemoryRead(mem_read), .EX_rt(ex_rt),
    .ID_rs(id_rs), .ID_rt(id_rt), .ID_UsesRs(uses_rs), .ID_UsesRt(uses_rt),
    .Flush(flush), .PC_WriteEnable(pc4), .IFID_WriteEnable(ifid4),
    .StallFlush(sf4), .Stalling(st4), .StallCount(cnt4), .ClearCount(clear_count));

  load_use_stall_ctrl #(.REG_ADDR_W(5), .LOAD_LATENCY(1), .CNT_W(2)) us (
    .clk(clk), .reset_n(reset_n), .EX_MemoryRead(mem_read), .EX_rt(ex_rt),
    .ID_rs(id_rs), .ID_rt(id_rt), .ID_UsesRs(uses_rs), .ID_UsesRt(uses_rt),
    .Flush(flush), .PC_WriteEnable(pcs), .IFID_WriteEnable(ifids),
    .StallFlush(sfs), .Stalling(sts), .StallCount(cnts), .ClearCount(clear_count));

  task automatic bubble();
    mem_read = 1'b0; ex_rt = '0; id_rs = '0; id_rt = '0;
    uses_rs = 1'b0; uses_rt = 1'b0; flush = 1'b0; clear_count = 1'b0;
  endtask

  task automatic rs_hazard();
    mem_read = 1'b1; ex_rt = 5'd8; id_rs = 5'd8; uses_rs = 1'b1;
    id_rt = 5'd2; uses_rt = 1'b1; flush = 1'b0;
  endtask

  // Leaves the bench at posedge+1 with all instances idle and counters cleared.
  task automatic do_reset();
    @(posedge clk); #1;
    bubble();
    reset_n = 1'b0;
    #2 reset_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    @(posedge clk); #1;
    rs_hazard();
    reset_n = 1'b0;
    #1;
    nvec++; if (pc1 !== 1'b1)   begin nerr++; $display("FAIL reset_pc got=%b exp=1", pc1); end
    nvec++; if (ifid1 !== 1'b1) begin nerr++; $display("FAIL reset_ifid got=%b exp=1", ifid1); end
    nvec++; if (sf1 !== 1'b0)   begin nerr++; $display("FAIL reset_sf got=%b exp=0", sf1); end
    @(posedge clk); #1;
    nvec++; if (st3 !== 1'b0)   begin nerr++; $display("FAIL reset_stalling got=%b exp=0", st3); end
    nvec++; if (cnt1 !== 16'd0) begin nerr++; $display("FAIL reset_count got=%0d exp=0", cnt1); end
    nvec++; if (sf3 !== 1'b0)   begin nerr++; $display("FAIL reset_sf3 got=%b exp=0", sf3); end
    bubble();
    reset_n = 1'b1;
  endtask

  task automatic test_single();
    do_reset();
    rs_hazard();
    #1;
    nvec++; if ({pc1, ifid1, sf1} !== 3'b001) begin nerr++; $display("FAIL single_stall got=%b exp=001", {pc1, ifid1, sf1}); end
    nvec++; if (st1 !== 1'b0) begin nerr++; $display("FAIL single_stalling got=%b exp=0", st1); end
    @(posedge clk); #1;
    bubble();
    #1;
    nvec++; if ({pc1, ifid1, sf1} !== 3'b110) begin nerr++; $display("FAIL single_release got=%b exp=110", {pc1, ifid1, sf1}); end
    nvec++; if (st1 !== 1'b0) begin nerr++; $display("FAIL single_stalling2 got=%b exp=0", st1); end
    nvec++; if (cnt1 !== 16'd1) begin nerr++; $display("FAIL single_count got=%0d exp=1", cnt1); end
  endtask

  task automatic test_multi_cycle();
    logic [3:0] exp_sf [1:4];
    logic [3:0] exp_st [1:4];
    exp_sf = '{1, 1, 1, 0};
    exp_st = '{0, 1, 1, 0};
    do_reset();
    rs_hazard();
    for (int c = 1; c <= 4; c++) begin
      #1;
      nvec++; if (sf3 !== exp_sf[c][0]) begin nerr++; $display("FAIL multi_sf c%0d got=%b exp=%b", c, sf3, exp_sf[c][0]); end
      nvec++; if (pc3 !== ~exp_sf[c][0]) begin nerr++; $display("FAIL multi_pc c%0d got=%b exp=%b", c, pc3, ~exp_sf[c][0]); end
      nvec++; if (st3 !== exp_st[c][0]) begin nerr++; $display("FAIL multi_stalling c%0d got=%b exp=%b", c, st3, exp_st[c][0]); end
      @(posedge clk); #1;
      bubble();
    end
    nvec++; if (cnt3 !== 16'd3) begin nerr++; $display("FAIL multi_count got=%0d exp=3", cnt3); end
  endtask

  task automatic test_zero_and_qualifiers();
    do_reset();
    mem_read = 1'b1; ex_rt = 5'd0; id_rs = 5'd0; uses_rs = 1'b1;
    #1;
    nvec++; if (sf1 !== 1'b0) begin nerr++; $display("FAIL zero_reg got=%b exp=0", sf1); end
    ex_rt = 5'd9; id_rs = 5'd0; uses_rs = 1'b0; id_rt = 5'd9; uses_rt = 1'b0;
    #1;
    nvec++; if (sf1 !== 1'b0) begin nerr++; $display("FAIL rt_unused got=%b exp=0", sf1); end
    uses_rt = 1'b1;
    #1;
    nvec++; if ({pc1, sf1} !== 2'b01) begin nerr++; $display("FAIL rt_used got=%b exp=01", {pc1, sf1}); end
    uses_rt = 1'b0; id_rs = 5'd3; uses_rs = 1'bx;
    #1;
    nvec++; if ({pc1, ifid1, sf1} !== 3'b110) begin nerr++; $display("FAIL x_use got=%b exp=110", {pc1, ifid1, sf1}); end
    id_rs = 5'd9; uses_rs = 1'b1; mem_read = 1'b0;
    #1;
    nvec++; if (sf1 !== 1'b0) begin nerr++; $display("FAIL not_load got=%b exp=0", sf1); end
    rs_hazard(); flush = 1'b1;
    #1;
    nvec++; if (sf1 !== 1'b0) begin nerr++; $display("FAIL idle_flush got=%b exp=0", sf1); end
    bubble();
  endtask

  task automatic test_flush();
    do_reset();
    rs_hazard();
    #1;
    nvec++; if (sf4 !== 1'b1) begin nerr++; $display("FAIL flush_c1 got=%b exp=1", sf4); end
    @(posedge clk); #1;
    bubble(); flush = 1'b1;
    #1;
    nvec++; if ({pc4, ifid4, sf4} !== 3'b110) begin nerr++; $display("FAIL flush_abort got=%b exp=110", {pc4, ifid4, sf4}); end
    nvec++; if (st4 !== 1'b1) begin nerr++; $display("FAIL flush_still_state got=%b exp=1", st4); end
    @(posedge clk); #1;
    flush = 1'b0;
    #1;
    nvec++; if (st4 !== 1'b0) begin nerr++; $display("FAIL flush_idle got=%b exp=0", st4); end
    nvec++; if (sf4 !== 1'b0) begin nerr++; $display("FAIL flush_post_sf got=%b exp=0", sf4); end
    nvec++; if (cnt4 !== 16'd1) begin nerr++; $display("FAIL flush_count got=%0d exp=1", cnt4); end
  endtask

  task automatic test_back_to_back();
    logic [1:0] exp_cnt;
    logic       exp_st3;
    do_reset();
    rs_hazard();
    for (int i = 1; i <= 5; i++) begin
      exp_st3 = ((i % 3) != 1);
      #1;
      nvec++; if (sfs !== 1'b1) begin nerr++; $display("FAIL b2b_sf i%0d got=%b exp=1", i, sfs); end
      nvec++; if (sf3 !== 1'b1) begin nerr++; $display("FAIL b2b_sf3 i%0d got=%b exp=1", i, sf3); end
      nvec++; if (st3 !== exp_st3) begin nerr++; $display("FAIL b2b_stalling3 i%0d got=%b exp=%b", i, st3, exp_st3); end
      @(posedge clk); #1;
      exp_cnt = (i < 3) ? 2'(i) : 2'd3;
      nvec++; if (cnts !== exp_cnt) begin nerr++; $display("FAIL sat_count i%0d got=%0d exp=%0d", i, cnts, exp_cnt); end
    end
    clear_count = 1'b1;
    #1;
    nvec++; if (sfs !== 1'b1) begin nerr++; $display("FAIL clear_sf got=%b exp=1", sfs); end
    @(posedge clk); #1;
    nvec++; if (cnts !== 2'd0) begin nerr++; $display("FAIL clear_count got=%0d exp=0", cnts); end
    bubble();
  endtask

  task automatic test_async_reset();
    do_reset();
    rs_hazard();
    @(posedge clk); #1;
    bubble();
    #1;
    nvec++; if ({st3, sf3} !== 2'b11) begin nerr++; $display("FAIL areset_pre got=%b exp=11", {st3, sf3}); end
    #2 reset_n = 1'b0;
    #1;
    nvec++; if ({pc3, ifid3, sf3} !== 3'b110) begin nerr++; $display("FAIL areset_out got=%b exp=110", {pc3, ifid3, sf3}); end
    nvec++; if (st3 !== 1'b0) begin nerr++; $display("FAIL areset_stalling got=%b exp=0", st3); end
    nvec++; if (cnt3 !== 16'd0) begin nerr++; $display("FAIL areset_count got=%0d exp=0", cnt3); end
    #1 reset_n = 1'b1;
    @(posedge clk); #1;
    nvec++; if ({st3, sf3, cnt3} !== 18'd0) begin nerr++; $display("FAIL areset_after got=%b/%b/%0d exp=0/0/0", st3, sf3, cnt3); end
  endtask

  initial begin
    bubble();
    reset_n = 1'b1;
    test_reset();
    test_single();
    test_multi_cycle();
    test_zero_and_qualifiers();
    test_flush();
    test_back_to_back();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
